move_cmd_gen: RTL and testbench
===============================

// Module: move_cmd_gen
// PURPOSE
//  Turns the five raw board buttons into clean, one-at-a-time move commands for the player logic.
//  Each button is synchronised, debounced and edge-detected. A held direction auto-repeats.
//  Commands go out over a valid/ready handshake to player_logic, and a centre press gives a one-cycle restart pulse.
//  Sits between the board button pins and player_logic in Maze; runs on the undivided board clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a button's debounced level changes (5 ms @100 MHz)
//  REPEAT_DELAY     40000000  cycles a direction must stay held before the first auto-repeat (0.4 s)
//  REPEAT_PERIOD    15000000  cycles between later auto-repeats while still held (0.15 s)
//  CNT_W            26      width of the debounce and repeat counters; must hold max(all three) - 1
// PORTS
//  clk         in   1  board clock; all logic on its rising edge
//  rst         in   1  synchronous reset, active high
//  btn_u       in   1  raw up button, asynchronous
//  btn_d       in   1  raw down button, asynchronous
//  btn_l       in   1  raw left button, asynchronous
//  btn_r       in   1  raw right button, asynchronous
//  btn_c       in   1  raw centre button, asynchronous
//  move_valid  out  1  a move command is being offered
//  move_dir    out  2  direction code (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3); valid only while move_valid=1
//  move_ready  in   1  player_logic accepts the command this cycle
//  restart     out  1  one-cycle pulse on a debounced press of the centre button
// BEHAVIOUR
//  Reset: move_valid=0, move_dir=DIR_UP, restart=0, FSM=IDLE, all debounced levels=0, all counters=0.
//  Synchroniser: two flops per button, so raw-to-synchronised latency is 2 cycles.
//  Debounce, per button:
//   - the counter clears whenever the synchronised level equals the debounced level;
//   - otherwise it increments, and when it reaches DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
//   - Any glitch shorter than DEBOUNCE_CYCLES cycles never reaches the debounced level.
//  Rise edge: rise_x = debounced_x & ~debounced_x_d1.
//  Direction select: if several directions are held, the fixed priority is U > D > L > R.
//   - Only the selected direction ("active") drives the FSM.
//  FSM:
//   - IDLE: on rise of any direction, latch active, offer the command, load the repeat counter with REPEAT_DELAY, go to HELD.
//   - HELD: the counter decrements each cycle while active stays held.
//     - At 0: offer the command again and reload with REPEAT_PERIOD.
//     - If the active button's debounced level drops, go to IDLE.
//     - If a higher-priority direction rises, switch active to it and treat it like a fresh press from IDLE.
//  Handshake (offer):
//   - Set move_valid=1 and move_dir=active, registered, so they appear 1 cycle after the event.
//   - move_valid and move_dir hold steady until move_ready=1 is seen; the transfer completes that cycle and move_valid=0 next cycle.
//   - At most one command is pending. An offer made while one is pending is dropped; there is no queue.
//   - Releasing the button does not withdraw a pending command.
//  Centre button:
//   - A rise on the centre button gives restart=1 for exactly 1 cycle.
//   - The same cycle clears move_valid and forces the FSM to IDLE.
//   - If a direction rises in the same cycle as the centre button, restart wins and that move is discarded.
//   - While the centre button stays held, no direction rise is accepted.
//  Reset mid-operation drops any pending command and the FSM state at once, and restart stays 0.
//  Counter widths: all comparisons are CNT_W-bit unsigned; repeat counter saturates at 0, never wraps.
// STRUCTURE
//  Shared package (maze_parameters.v) holds:
//   - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT 2-bit localparams;
//   - the FSM state encodings IDLE=1'b0, HELD=1'b1.
//  Sub-module btn_debounce: synchroniser, debounce counter and rise output.
//   - Parameterised by DEBOUNCE_CYCLES and CNT_W; instantiated 5 times.
//  move_cmd_gen itself holds the priority select, repeat FSM, handshake register and restart logic.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, move_ready tied 1 unless stated)
//  1. Drive btn_u with a 2-cycle glitch -> no move_valid. Then hold btn_u high 6 cycles and release -> exactly one move_valid pulse with move_dir=0.
//  2. Hold btn_r for 50 cycles -> valid pulses with dir=3 at the first press, then 20 cycles later, then every 8 cycles after that (4 pulses total).
//  3. Hold move_ready=0 and press btn_l, then btn_d -> move_valid stays 1 with dir=2. Raise move_ready at cycle 30 -> one transfer of dir=2 only; the dir=1 offer is dropped.
//  4. Press btn_l and btn_u in the same cycle -> dir=0. Then release btn_u while btn_l is still held -> back to IDLE and no new move until btn_l is pressed again.
//  5. Press btn_c with a move pending (ready=0) -> restart high exactly 1 cycle and move_valid=0 the next cycle. Pressing btn_u while btn_c is held -> no move.
//  6. Assert rst during HELD with a pending move -> next cycle move_valid=0 and restart=0. After releasing rst with btn_u already held -> no command until a fresh press.

Source files
------------

// File: rtl/move_cmd_gen_pkg.sv
// Shared definitions for the move command generator: direction codes, FSM
// states and the fixed direction priority.
package move_cmd_gen_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned BTN_C   = 4;

  // Lowest direction code wins: U > D > L > R.
  function automatic dir_e pick_dir(input logic [3:0] req);
    dir_e d;
    if (req[0])      d = DIR_UP;
    else if (req[1]) d = DIR_DOWN;
    else if (req[2]) d = DIR_LEFT;
    else             d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/move_cmd_gen_btn_debounce.sv
// One button: two-flop synchroniser, stable-count debouncer and rise detect.
module move_cmd_gen_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_d1_q;
  logic             armed_q;

  // Synchroniser keeps tracking the pin through reset so a button held
  // across reset is recognised as already down.
  always_ff @(posedge clk_i) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
  end

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      level_d1_q <= level_q;
      armed_q    <= armed_q | ~sync2_q;
    end
  end

  // A rise only counts once the button has been seen released since reset.
  assign level_o = level_q;
  assign rise_o  = level_q & ~level_d1_q & armed_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Board buttons to one-at-a-time move commands with auto-repeat, a
// valid/ready handshake towards player_logic and a centre restart pulse.
module move_cmd_gen
  import move_cmd_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 40000000,
  parameter int unsigned REPEAT_PERIOD   = 15000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ready,
  output logic       restart
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_rise;

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    move_cmd_gen_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i  (clk),
      .rst_i  (rst),
      .btn_i  (btn_raw[i]),
      .level_o(btn_lvl[i]),
      .rise_o (btn_rise[i])
    );
  end

  state_e           state_q;
  dir_e             active_q;
  logic [CNT_W-1:0] rpt_q;
  logic             move_valid_q;
  dir_e             move_dir_q;
  logic             restart_q;

  logic [3:0] dir_lvl;
  logic [3:0] dir_rise;
  dir_e       rise_dir;
  logic       fresh_d;
  logic       offer_d;
  dir_e       offer_dir_d;

  // Direction rises are ignored while the centre button is down.
  always_comb begin
    dir_lvl  = btn_lvl[3:0];
    dir_rise = btn_rise[3:0] & {4{~btn_lvl[BTN_C]}};
    rise_dir = pick_dir(dir_rise);
    fresh_d  = (|dir_rise) && ((state_q == IDLE) || (rise_dir < active_q));
    offer_d  = fresh_d ||
               ((state_q == HELD) && dir_lvl[active_q] && (rpt_q <= CNT_W'(1)));
    offer_dir_d = fresh_d ? rise_dir : active_q;
  end

  // The repeat fires on the cycle the counter would reach 0, giving exactly
  // REPEAT_DELAY / REPEAT_PERIOD cycles between offers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      active_q     <= DIR_UP;
      rpt_q        <= '0;
      move_valid_q <= 1'b0;
      move_dir_q   <= DIR_UP;
      restart_q    <= 1'b0;
    end else begin
      restart_q <= btn_rise[BTN_C];
      if (btn_rise[BTN_C]) begin
        move_valid_q <= 1'b0;
        state_q      <= IDLE;
      end else begin
        if (fresh_d) begin
          active_q <= rise_dir;
          rpt_q    <= CNT_W'(REPEAT_DELAY);
          state_q  <= HELD;
        end else if (state_q == HELD) begin
          if (!dir_lvl[active_q])         state_q <= IDLE;
          else if (rpt_q <= CNT_W'(1))    rpt_q   <= CNT_W'(REPEAT_PERIOD);
          else                            rpt_q   <= rpt_q - CNT_W'(1);
        end

        // Single slot: a new offer only lands if the slot is free or draining.
        if (offer_d && (!move_valid_q || move_ready)) begin
          move_valid_q <= 1'b1;
          move_dir_q   <= offer_dir_d;
        end else if (move_ready) begin
          move_valid_q <= 1'b0;
        end
      end
    end
  end

  assign move_valid = move_valid_q;
  assign move_dir   = move_dir_q;
  assign restart    = restart_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Bench for move_cmd_gen with short timing parameters.
module tb_move_cmd_gen;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
  logic       move_ready = 1'b1;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       restart;

  always #5 clk = ~clk;

  move_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (26)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_u     (btn_u),
    .btn_d     (btn_d),
    .btn_l     (btn_l),
    .btn_r     (btn_r),
    .btn_c     (btn_c),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .move_ready(move_ready),
    .restart   (restart)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state; button index 0..4 = U, D, L, R, C.
  bit m_s1[5], m_s2[5], m_deb[5], m_prev[5], m_arm[5];
  int m_run[5];
  bit m_held;
  int m_act;
  int m_due;
  bit m_valid;
  int m_dir;
  bit m_restart;

  int obs_xfer, obs_restart, obs_dir, obs_valid;

  function automatic bit raw_of(input int b);
    case (b)
      0: return btn_u;
      1: return btn_d;
      2: return btn_l;
      3: return btn_r;
      default: return btn_c;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // One clock edge of the behavioural model, driven by the pre-edge inputs.
  task automatic model_step();
    bit rise[5];
    bit lvl[5];
    bit offer;
    int best;
    for (int b = 0; b < 5; b++) begin
      lvl[b]  = m_deb[b];
      rise[b] = m_deb[b] && !m_prev[b] && m_arm[b];
    end
    if (rst) begin
      for (int b = 0; b < 5; b++) begin
        m_deb[b] = 0; m_prev[b] = 0; m_arm[b] = 0; m_run[b] = 0;
      end
      m_held = 0; m_valid = 0; m_dir = 0; m_restart = 0;
    end else begin
      for (int b = 0; b < 5; b++) begin
        m_prev[b] = m_deb[b];
        m_arm[b]  = m_arm[b] | !m_s2[b];
        if (m_s2[b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == int'(DB)) begin
            m_deb[b] = !m_deb[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      if (rise[4]) begin
        m_restart = 1; m_valid = 0; m_held = 0;
      end else begin
        m_restart = 0;
        offer = 0;
        best = -1;
        for (int d = 0; d < 4; d++)
          if (rise[d] && !lvl[4] && best < 0) best = d;
        if (best >= 0 && (!m_held || best < m_act)) begin
          m_act = best; m_held = 1; m_due = cyc + int'(RD); offer = 1;
        end else if (m_held && !lvl[m_act]) begin
          m_held = 0;
        end else if (m_held && cyc == m_due) begin
          offer = 1; m_due = cyc + int'(RP);
        end
        if (offer && (!m_valid || move_ready)) begin
          m_valid = 1; m_dir = m_act;
        end else if (m_valid && move_ready) begin
          m_valid = 0;
        end
      end
    end
    for (int b = 0; b < 5; b++) begin
      m_s2[b] = m_s1[b];
      m_s1[b] = raw_of(b);
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_valid", int'(move_valid), int'(m_valid));
    chk("model_restart", int'(restart), int'(m_restart));
    if (m_valid) chk("model_dir", int'(move_dir), m_dir);
    if (move_valid && move_ready) begin obs_xfer++; obs_dir = int'(move_dir); end
    if (move_valid) obs_valid++;
    if (restart) obs_restart++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_obs();
    obs_xfer = 0; obs_restart = 0; obs_dir = -1; obs_valid = 0;
  endtask

  task automatic set_btn(input logic [4:0] m);
    {btn_c, btn_r, btn_l, btn_d, btn_u} = m;
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      if (move_valid) begin lat = k; break; end
    end
  endtask

  typedef struct {
    logic [4:0] btn;
    int         hold;
    int         xfers;
    int         dir;
    int         restarts;
  } vec_t;

  vec_t tbl[15];
  int   pulses[$];

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c0;
    logic [4:0] m;

    tbl[0]  = '{5'b00001,  2, 0, 0, 0};
    tbl[1]  = '{5'b00001,  3, 0, 0, 0};
    tbl[2]  = '{5'b00001,  4, 1, 0, 0};
    tbl[3]  = '{5'b00001,  6, 1, 0, 0};
    tbl[4]  = '{5'b00010, 10, 1, 1, 0};
    tbl[5]  = '{5'b00100, 10, 1, 2, 0};
    tbl[6]  = '{5'b01000, 10, 1, 3, 0};
    tbl[7]  = '{5'b00101, 10, 1, 0, 0};
    tbl[8]  = '{5'b01010, 10, 1, 1, 0};
    tbl[9]  = '{5'b10000, 10, 0, 0, 1};
    tbl[10] = '{5'b01000, 20, 1, 3, 0};
    tbl[11] = '{5'b01000, 21, 2, 3, 0};
    tbl[12] = '{5'b00100, 28, 2, 2, 0};
    tbl[13] = '{5'b00100, 29, 3, 2, 0};
    tbl[14] = '{5'b10001, 10, 0, 0, 1};

    clear_obs();
    rst = 1'b1;
    set_btn('0);
    run(4);
    chk("reset_valid", int'(move_valid), 0);
    chk("reset_dir", int'(move_dir), 0);
    chk("reset_restart", int'(restart), 0);
    rst = 1'b0;
    run(5);

    for (int i = 0; i < 15; i++) begin
      clear_obs();
      set_btn(tbl[i].btn);
      run(tbl[i].hold);
      set_btn('0);
      run(20);
      chk($sformatf("vec%0d_xfers", i), obs_xfer, tbl[i].xfers);
      if (tbl[i].xfers > 0) chk($sformatf("vec%0d_dir", i), obs_dir, tbl[i].dir);
      chk($sformatf("vec%0d_restarts", i), obs_restart, tbl[i].restarts);
    end

    // Held right: first offer, then REPEAT_DELAY, then REPEAT_PERIOD spacing.
    set_btn(5'b01000);
    c0 = cyc;
    pulses.delete();
    for (int k = 0; k < 50; k++) begin
      step();
      if (move_valid) pulses.push_back(cyc);
    end
    set_btn('0);
    run(20);
    chk("t2_first_latency", (pulses.size() > 0) ? pulses[0] - c0 : -1, 7);
    chk("t2_at_least_4", int'(pulses.size() >= 4), 1);
    for (int k = 1; k < 4 && k < pulses.size(); k++)
      chk($sformatf("t2_gap%0d", k), pulses[k] - pulses[k-1], (k == 1) ? int'(RD) : int'(RP));

    // Stalled handshake: first command held, later higher-priority offer dropped.
    move_ready = 1'b0;
    clear_obs();
    set_btn(5'b00100);
    run(5);
    set_btn(5'b00110);
    run(15);
    set_btn('0);
    run(9);
    chk("t3_valid_cycles", obs_valid, 23);
    chk("t3_pending_valid", int'(move_valid), 1);
    chk("t3_pending_dir", int'(move_dir), 2);
    move_ready = 1'b1;
    step();
    chk("t3_after_xfer", int'(move_valid), 0);
    clear_obs();
    run(20);
    chk("t3_no_second", obs_valid, 0);

    // Simultaneous L+U picks U; releasing U with L held gives nothing new.
    clear_obs();
    set_btn(5'b00101);
    run(12);
    chk("t4_xfers", obs_xfer, 1);
    chk("t4_dir", obs_dir, 0);
    set_btn(5'b00100);
    clear_obs();
    run(40);
    chk("t4_quiet_after_u_release", obs_valid, 0);
    set_btn('0);
    run(15);
    set_btn(5'b00100);
    wait_valid(15, lat);
    chk("t4_repress_latency", lat, 7);
    chk("t4_repress_dir", int'(move_dir), 2);
    set_btn('0);
    run(15);

    // Centre press with a command pending.
    move_ready = 1'b0;
    set_btn(5'b00001);
    run(10);
    set_btn('0);
    run(10);
    chk("t5_pending_after_release", int'(move_valid), 1);
    set_btn(5'b10000);
    run(6);
    chk("t5_restart_early", int'(restart), 0);
    step();
    chk("t5_restart_pulse", int'(restart), 1);
    chk("t5_valid_cleared", int'(move_valid), 0);
    step();
    chk("t5_restart_one_cycle", int'(restart), 0);
    clear_obs();
    set_btn(5'b10001);
    run(20);
    chk("t5_no_move_while_c", obs_valid, 0);
    chk("t5_no_extra_restart", obs_restart, 0);
    set_btn('0);
    run(15);
    move_ready = 1'b1;

    // Reset mid-operation, with buttons held across reset.
    move_ready = 1'b0;
    set_btn(5'b01000);
    run(12);
    chk("t6_pending_before_rst", int'(move_valid), 1);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", int'(move_valid), 0);
    chk("t6_rst_restart", int'(restart), 0);
    chk("t6_rst_dir", int'(move_dir), 0);
    set_btn(5'b01001);
    run(5);
    rst = 1'b0;
    clear_obs();
    run(30);
    chk("t6_no_cmd_held_across_rst", obs_valid, 0);
    chk("t6_no_restart", obs_restart, 0);
    set_btn('0);
    run(15);
    move_ready = 1'b1;
    set_btn(5'b00001);
    wait_valid(15, lat);
    chk("t6_fresh_latency", lat, 7);
    chk("t6_fresh_dir", int'(move_dir), 0);
    set_btn('0);
    run(15);

    // Randomised segments against the model.
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: m = 5'(1) << $urandom_range(0, 3);
        4:          m = 5'($urandom_range(1, 15));
        5:          m = 5'b10000;
        6:          m = 5'($urandom_range(0, 31));
        default:    m = '0;
      endcase
      set_btn(m);
      for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
        move_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 199) == 0);
        step();
      end
      rst = 1'b0;
    end
    move_ready = 1'b1;
    set_btn('0);
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
